// File: rtl/lm32_trace_ring_if.sv
// Host bus bundle for the LM32 PC trace ring: strobe/ack handshake with
// byte selects, byte address and 32-bit data in each direction.
interface lm32_trace_ring_if;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic        ack_o;
    logic [31:0] dat_o;

    modport master (
        output stb_i, we_i, sel_i, adr_i, dat_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  stb_i, we_i, sel_i, adr_i, dat_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/lm32_trace_ring.sv
// Circular PC trace recorder with pre/post-trigger capture, PC-range
// comparators and a host register/memory window on a simple slave bus.
module lm32_trace_ring #(
    parameter int PC_WIDTH       = 30,
    parameter int DEPTH          = 256,
    parameter int NUM_RANGES     = 2,
    parameter int EID_WIDTH      = 3,
    parameter int EID_BREAKPOINT = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    lm32_trace_ring_if.slave     bus,
    input  logic [PC_WIDTH-1:0]  trace_pc,
    input  logic                 trace_pc_valid,
    input  logic [EID_WIDTH-1:0] trace_eid,
    input  logic                 trace_exception,
    input  logic                 trace_eret,
    input  logic                 trace_bret,
    output logic                 trace_irq_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    state_t                r_state;
    state_t                w_state_nx;
    logic [4:0]            r_trig_en;
    logic [AW-1:0]         r_wptr;
    logic                  r_wrapped;
    logic                  r_triggered;
    logic [AW:0]           r_postlen;
    logic [AW-1:0]         r_trigpos;
    logic [AW:0]           r_cnt;
    logic [31:0]           r_pc_low  [NUM_RANGES];
    logic [31:0]           r_pc_high [NUM_RANGES];
    logic                  r_ack;
    logic [31:0]           r_dat;
    logic                  r_irq;
    logic [PC_WIDTH-1:0]   r_mem [DEPTH];

    logic                  w_acc;
    logic                  w_reg_wr;
    logic [11:0]           w_off;
    logic [AW-1:0]         w_mem_adr;
    logic                  w_arm;
    logic                  w_stop;
    logic [31:0]           w_pc_byte;
    logic [NUM_RANGES-1:0] w_hit;
    logic [4:0]            w_src;
    logic                  w_trig;
    logic                  w_clear;
    logic                  w_wr;
    logic                  w_take;
    logic [31:0]           w_postlen_m;
    logic [31:0]           w_reg_rd;
    logic                  w_unused_bits;

    assign w_acc       = bus.stb_i & ~r_ack;
    assign w_reg_wr    = w_acc & bus.we_i & bus.adr_i[12];
    assign w_off       = bus.adr_i[11:0];
    assign w_mem_adr   = bus.adr_i[AW+1:2];
    assign w_arm       = w_reg_wr & (w_off == 12'h000) & bus.sel_i[3] & bus.dat_i[31];
    assign w_stop      = w_reg_wr & (w_off == 12'h000) & bus.sel_i[3] & bus.dat_i[30];
    assign w_pc_byte   = 32'({trace_pc, 2'b00});
    assign w_postlen_m = byte_merge(32'(r_postlen), bus.dat_i, bus.sel_i);

    assign w_unused_bits = ^{bus.adr_i[31:13], bus.adr_i[1:0], w_postlen_m[31:AW+1]};

    // Range comparators; an inverted range (low > high) can never match.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_RANGES; k++) begin
            w_hit[k] = (w_pc_byte >= r_pc_low[k]) && (w_pc_byte <= r_pc_high[k]);
        end
    end

    assign w_src = {
        trace_exception & (trace_eid == EID_WIDTH'(EID_BREAKPOINT)),
        trace_exception & (trace_eid != EID_WIDTH'(EID_BREAKPOINT)),
        (|w_hit) & trace_pc_valid,
        trace_eret,
        trace_bret
    };
    assign w_trig = |(w_src & r_trig_en);

    // Capture FSM next state; STOP outranks ARM, ARM outranks a trigger.
    always_comb begin
        w_state_nx = r_state;
        w_clear    = 1'b0;
        w_wr       = 1'b0;
        w_take     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_stop) begin
                    w_state_nx = ST_DONE;
                end else if (w_arm) begin
                    w_state_nx = ST_ARMED;
                    w_clear    = 1'b1;
                end else begin
                    w_state_nx = r_state;
                end
            end
            ST_ARMED: begin
                w_wr = trace_pc_valid;
                if (w_stop) begin
                    w_state_nx = ST_DONE;
                end else if (w_arm) begin
                    w_state_nx = ST_ARMED;
                    w_clear    = 1'b1;
                end else if (w_trig) begin
                    w_take     = 1'b1;
                    w_state_nx = (r_postlen == (AW+1)'(0)) ? ST_DONE : ST_POST;
                end else begin
                    w_state_nx = ST_ARMED;
                end
            end
            ST_POST: begin
                w_wr = trace_pc_valid;
                if (w_stop) begin
                    w_state_nx = ST_DONE;
                end else if (w_arm) begin
                    w_state_nx = ST_ARMED;
                    w_clear    = 1'b1;
                end else if (trace_pc_valid && (r_cnt == (AW+1)'(1))) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_POST;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State register and level interrupt that tracks DONE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_irq   <= (w_state_nx == ST_DONE);
        end
    end

    // Write pointer, wrap flag, trigger bookkeeping and post-trigger counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr      <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
            r_trigpos   <= '0;
            r_cnt       <= '0;
        end else if (w_clear) begin
            r_wptr      <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
                if (r_wptr == AW'(DEPTH-1)) begin
                    r_wrapped <= 1'b1;
                end
            end
            if (w_take) begin
                r_trigpos   <= r_wptr;
                r_triggered <= 1'b1;
                r_cnt       <= r_postlen;
            end else if (w_wr && (r_state == ST_POST)) begin
                r_cnt <= r_cnt - (AW+1)'(1);
            end
        end
    end

    // Trace memory write port; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr] <= trace_pc;
        end
    end

    // Control register read mux; unmapped offsets fall through to zero.
    always_comb begin
        w_reg_rd = 32'd0;
        case (w_off)
            12'h000: w_reg_rd = {r_state, 20'd0, r_wrapped, r_triggered, 3'd0, r_trig_en};
            12'h004: w_reg_rd = 32'(r_wptr);
            12'h008: w_reg_rd = 32'(r_postlen);
            12'h00C: w_reg_rd = 32'(r_trigpos);
            default: w_reg_rd = 32'd0;
        endcase
        for (int k = 0; k < NUM_RANGES; k++) begin
            w_reg_rd = w_reg_rd
                     | ((w_off == 12'(16 + 8*k)) ? r_pc_low[k]  : 32'd0)
                     | ((w_off == 12'(20 + 8*k)) ? r_pc_high[k] : 32'd0);
        end
    end

    // Host register writes, one-cycle ack and registered read data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_trig_en <= '0;
            r_postlen <= '0;
            r_ack     <= 1'b0;
            r_dat     <= 32'd0;
            for (int k = 0; k < NUM_RANGES; k++) begin
                r_pc_low[k]  <= 32'd0;
                r_pc_high[k] <= 32'd0;
            end
        end else begin
            r_ack <= w_acc;
            if (w_acc) begin
                r_dat <= bus.we_i ? 32'd0
                       : (bus.adr_i[12] ? w_reg_rd : 32'(r_mem[w_mem_adr]));
            end
            if (w_reg_wr) begin
                if ((w_off == 12'h000) && bus.sel_i[0]) begin
                    r_trig_en <= bus.dat_i[4:0];
                end
                if (w_off == 12'h008) begin
                    r_postlen <= w_postlen_m[AW:0];
                end
                for (int k = 0; k < NUM_RANGES; k++) begin
                    if (w_off == 12'(16 + 8*k)) begin
                        r_pc_low[k] <= byte_merge(r_pc_low[k], bus.dat_i, bus.sel_i);
                    end
                    if (w_off == 12'(20 + 8*k)) begin
                        r_pc_high[k] <= byte_merge(r_pc_high[k], bus.dat_i, bus.sel_i);
                    end
                end
            end
        end
    end

    assign bus.ack_o   = r_ack;
    assign bus.dat_o   = r_dat;
    assign trace_irq_o = r_irq;

endmodule

// File: tb/tb_lm32_trace_ring.sv
// Directed bench for lm32_trace_ring: bus handshake, trigger sources,
// wrap-around, STOP/ARM interplay and asynchronous reset.
module tb_lm32_trace_ring;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [29:0] trace_pc;
    logic        trace_pc_valid;
    logic [2:0]  trace_eid;
    logic        trace_exception;
    logic        trace_eret;
    logic        trace_bret;
    logic        trace_irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    lm32_trace_ring_if bus ();

    lm32_trace_ring dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .bus             (bus.slave),
        .trace_pc        (trace_pc),
        .trace_pc_valid  (trace_pc_valid),
        .trace_eid       (trace_eid),
        .trace_exception (trace_exception),
        .trace_eret      (trace_eret),
        .trace_bret      (trace_bret),
        .trace_irq_o     (trace_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b1;
        bus.adr_i = adr;
        bus.dat_i = dat;
        bus.sel_i = sel;
        @(posedge clk_i); #1;
        check("wr_ack", 32'(bus.ack_o), 32'd1);
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic bus_rd(input logic [31:0] adr, output logic [31:0] dat);
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = adr;
        bus.sel_i = 4'hF;
        @(posedge clk_i); #1;
        check("rd_ack", 32'(bus.ack_o), 32'd1);
        dat       = bus.dat_o;
        bus.stb_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic samp(input logic [29:0] pc, input logic vld, input logic bret,
                        input logic exc, input logic [2:0] eid);
        trace_pc        = pc;
        trace_pc_valid  = vld;
        trace_bret      = bret;
        trace_exception = exc;
        trace_eid       = eid;
        @(posedge clk_i); #1;
        trace_pc_valid  = 1'b0;
        trace_bret      = 1'b0;
        trace_exception = 1'b0;
        trace_eid       = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        rst_n_i         = 1'b0;
        trace_pc        = 30'd0;
        trace_pc_valid  = 1'b0;
        trace_eid       = 3'd0;
        trace_exception = 1'b0;
        trace_eret      = 1'b0;
        trace_bret      = 1'b0;
        bus.stb_i       = 1'b0;
        bus.we_i        = 1'b0;
        bus.sel_i       = 4'h0;
        bus.adr_i       = 32'd0;
        bus.dat_i       = 32'd0;

        // Reset state and handshake timing
        #1;
        check("rst_ack", 32'(bus.ack_o), 32'd0);
        check("rst_dat", bus.dat_o, 32'd0);
        check("rst_irq", 32'(trace_irq_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        bus_rd(32'h1000, rd);
        check("rst_ctrl", rd, 32'h0000_0000);
        bus.stb_i = 1'b1;
        bus.adr_i = 32'h1000;
        #1 check("b2b_ack0", 32'(bus.ack_o), 32'd0);
        @(posedge clk_i); #1 check("b2b_ack1", 32'(bus.ack_o), 32'd1);
        @(posedge clk_i); #1 check("b2b_idle", 32'(bus.ack_o), 32'd0);
        @(posedge clk_i); #1 check("b2b_ack2", 32'(bus.ack_o), 32'd1);
        bus.stb_i = 1'b0;
        @(posedge clk_i); #1 check("b2b_drop", 32'(bus.ack_o), 32'd0);

        // bret trigger with POSTLEN=3
        bus_wr(32'h1000, 32'h0000_0001, 4'b0001);
        bus_wr(32'h1008, 32'd3, 4'b1111);
        bus_wr(32'h1000, 32'h8000_0000, 4'b1000);
        bus_rd(32'h1000, rd);
        check("t2_armed", rd, 32'h4000_0001);
        for (int i = 0; i < 5; i++) samp(30'h100 + 30'(i), 1'b1, 1'b0, 1'b0, 3'd0);
        samp(30'h105, 1'b1, 1'b1, 1'b0, 3'd0);
        for (int i = 6; i < 10; i++) samp(30'h100 + 30'(i), 1'b1, 1'b0, 1'b0, 3'd0);
        check("t2_irq", 32'(trace_irq_o), 32'd1);
        bus_rd(32'h1000, rd);
        check("t2_ctrl", rd, 32'hC000_0101);
        bus_rd(32'h100C, rd);
        check("t2_trigpos", rd, 32'd5);
        bus_rd(32'h1004, rd);
        check("t2_wptr", rd, 32'd9);
        for (int i = 5; i < 9; i++) begin
            bus_rd(32'(4 * i), rd);
            check("t2_mem", rd, 32'h100 + 32'(i));
        end

        // Range trigger after wrap-around
        bus_wr(32'h1000, 32'h0000_0004, 4'b0001);
        bus_wr(32'h1008, 32'd0, 4'b1111);
        bus_wr(32'h1018, 32'h0000_2000, 4'b1111);
        bus_wr(32'h101C, 32'h0000_20FC, 4'b1111);
        bus_rd(32'h101C, rd);
        check("t3_pchigh", rd, 32'h0000_20FC);
        bus_wr(32'h1000, 32'h8000_0000, 4'b1000);
        for (int i = 0; i < 300; i++) samp(30'h1000 + 30'(i), 1'b1, 1'b0, 1'b0, 3'd0);
        bus_rd(32'h1000, rd);
        check("t3_no_trig", rd, 32'h4000_0204);
        samp(30'h800, 1'b1, 1'b0, 1'b0, 3'd0);
        bus_rd(32'h1000, rd);
        check("t3_ctrl", rd, 32'hC000_0304);
        bus_rd(32'h100C, rd);
        check("t3_trigpos", rd, 32'd44);
        bus_rd(32'h1004, rd);
        check("t3_wptr", rd, 32'd45);
        bus_rd(32'h00B0, rd);
        check("t3_mem44", rd, 32'h800);
        bus_rd(32'h0000, rd);
        check("t3_mem0", rd, 32'h1100);
        bus_rd(32'h1FF0, rd);
        check("t3_unmapped", rd, 32'd0);

        // Exception sources with POSTLEN=0
        bus_wr(32'h1000, 32'h0000_0008, 4'b0001);
        bus_wr(32'h1000, 32'h8000_0000, 4'b1000);
        samp(30'h200, 1'b1, 1'b0, 1'b1, 3'd1);
        bus_rd(32'h1000, rd);
        check("t4_bp_ignored", rd, 32'h4000_0008);
        samp(30'h201, 1'b1, 1'b0, 1'b1, 3'd2);
        check("t4_irq", 32'(trace_irq_o), 32'd1);
        samp(30'h202, 1'b1, 1'b0, 1'b0, 3'd0);
        bus_rd(32'h1000, rd);
        check("t4_ctrl", rd, 32'hC000_0108);
        bus_rd(32'h1004, rd);
        check("t4_wptr", rd, 32'd2);
        bus_rd(32'h100C, rd);
        check("t4_trigpos", rd, 32'd1);
        bus_rd(32'h0004, rd);
        check("t4_mem1", rd, 32'h201);

        // STOP beats ARM, then re-ARM
        bus_wr(32'h1000, 32'h8000_0000, 4'b1000);
        for (int i = 0; i < 3; i++) samp(30'h300 + 30'(i), 1'b1, 1'b0, 1'b0, 3'd0);
        bus_wr(32'h1000, 32'hC000_0000, 4'b1000);
        bus_rd(32'h1000, rd);
        check("t5_stop", rd, 32'hC000_0008);
        bus_rd(32'h1004, rd);
        check("t5_wptr", rd, 32'd3);
        bus_wr(32'h1000, 32'h8000_0000, 4'b1000);
        bus_rd(32'h1000, rd);
        check("t5_rearm", rd, 32'h4000_0008);
        bus_rd(32'h1004, rd);
        check("t5_wptr0", rd, 32'd0);

        // Asynchronous reset during POST
        bus_wr(32'h1000, 32'h0000_0001, 4'b0001);
        bus_wr(32'h1008, 32'd5, 4'b1111);
        bus_wr(32'h1000, 32'h8000_0000, 4'b1000);
        samp(30'h400, 1'b1, 1'b1, 1'b0, 3'd0);
        bus_rd(32'h1000, rd);
        check("t6_post", rd, 32'h8000_0101);
        bus.stb_i = 1'b1;
        bus.adr_i = 32'h1000;
        @(posedge clk_i); #1;
        check("t6_ack_pre", 32'(bus.ack_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check("t6_ack_rst", 32'(bus.ack_o), 32'd0);
        check("t6_irq_rst", 32'(trace_irq_o), 32'd0);
        bus.stb_i = 1'b0;
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        bus_rd(32'h1000, rd);
        check("t6_ctrl", rd, 32'h0000_0000);
        bus_rd(32'h1008, rd);
        check("t6_postlen", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
